demux_buf: RTL and testbench
============================

Name: demux_buf

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake; the inverse of the datapath 2:1 mux.
- Routes one WIDTH-bit word per accepted transfer to output 0 or output 1, selected by ctrl.
- Each output has its own small FIFO, so a stalled consumer on one side does not block the other side.
- Sits between a producer (e.g. ALU/write-back result) and two consumers (e.g. register-file write port and memory store path).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.
- AW, log2(DEPTH), pointer width; derived locally, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ctrl  input  1  destination select: 0 -> out0, 1 -> out1; sampled with in_valid.
- in  input  WIDTH  data word to route.
- in_valid  input  1  producer has a word on in/ctrl.
- in_ready  output  1  block accepts the word this cycle.
- out0  output  WIDTH  head word of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 takes the head word.
- out1  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes the head word.
- cnt0  output  16  delivered-word count, output 0 (only with DEMUX_CNT_EN).
- cnt1  output  16  delivered-word count, output 1 (only with DEMUX_CNT_EN).

Behaviour:
- Reset (async, rst_n=0):
  - All read/write pointers and occupancy counts cleared.
  - out0_valid=0, out1_valid=0, out0=0, out1=0.
  - in_ready reflects empty FIFOs (1) once rst_n=1.
  - FIFO storage is not reset.
- Assertion mid-operation discards all buffered words immediately; no partial delivery.
- in_ready is combinational: ~full[ctrl]. It depends on ctrl only, never on in_valid.
- Push: when in_valid & in_ready at a clock edge, in is written to FIFO[ctrl] at its write pointer; the write pointer increments.
- Pop: when outN_valid & outN_ready at a clock edge, FIFO N's read pointer increments.
- outN_valid = (countN != 0).
- outN = storage[rdptrN] when outN_valid, else 0.
- Latency: a word accepted at edge k is visible on outN with outN_valid=1 after edge k. There is no combinational path from in to outN.
- Ordering:
  - Per-output FIFO order is preserved.
  - No ordering relation exists between out0 and out1.
- Pointers wrap modulo DEPTH (AW bits). Counts are AW+1 bits, range 0..DEPTH.
- Full FIFO: in_ready=0 for that ctrl, even if the same FIFO pops this cycle (no pass-through). The other FIFO remains accessible by switching ctrl.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Pop on an empty FIFO cannot occur, since valid=0. outN_ready is ignored while outN_valid=0.
- Pushes to one FIFO and pops from the other in the same cycle are independent.
- ctrl and in may change freely while in_valid=0. They are sampled only on an accepted transfer.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt0/cnt1 ports exist; each is a 16-bit register, reset to 0 by rst_n.
  - cntN increments by 1 on every outN handshake and wraps 16'hFFFF -> 16'h0000.
- Undefined:
  - cnt0/cnt1 ports and their logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 20 ns, then release -> out0_valid=out1_valid=0, out0=out1=0, in_ready=1 for both ctrl values.
- Route one word each way: push 32'hffff0000 with ctrl=0, then 32'h0000ffff with ctrl=1, both readys high -> out0=32'hffff0000 one cycle after its accept, out1=32'h0000ffff one cycle after its accept, each valid for exactly one cycle.
- Backpressure/full: out0_ready=0, push 32'h1, 32'h2 with ctrl=0 -> in_ready=0 with ctrl=0; ctrl=1 push 32'h3 accepted. Then raise out0_ready -> out0 delivers 1 then 2 in order.
- Full plus pop same cycle: FIFO 0 full, out0_ready=1, in_valid=1, ctrl=0 -> push refused that cycle (in_ready=0), accepted next cycle; no word lost or duplicated.
- Reset mid-operation: two words buffered in each FIFO, pulse rst_n low asynchronously between edges -> outN_valid drop to 0 immediately; after release no stale word appears.
- With DEMUX_CNT_EN: deliver 5 words to out0 and 3 to out1 -> cnt0=5, cnt1=3. Preload a count at 16'hFFFF via 65535 deliveries, then deliver one more -> the count reads 16'h0000.

Source files
------------

// File: rtl/demux_buf.sv
// demux_buf: registered 1-to-2 demultiplexer with valid/ready handshake.
// Each accepted word goes to FIFO[ctrl]. Each output has its own FIFO, so a
// stalled consumer on one side does not block the other side.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ctrl, in, in_valid     producer side: destination select, word, valid
//   in_ready               combinational, ~full[ctrl]; does not depend on in_valid
//   out0, out0_valid       head of FIFO 0 (zero when empty), non-empty flag
//   out0_ready             consumer 0 takes the head word
//   out1, out1_valid       head of FIFO 1 (zero when empty), non-empty flag
//   out1_ready             consumer 1 takes the head word
//   cnt0, cnt1             16-bit delivered-word counters (only with DEMUX_CNT_EN)
//
// Optional feature macro: DEMUX_CNT_EN adds the cnt0/cnt1 delivery counters.

module demux_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
`ifdef DEMUX_CNT_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    input  logic             out1_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];

    logic [AW-1:0] wr0_q, wr0_d, rd0_q, rd0_d;
    logic [AW-1:0] wr1_q, wr1_d, rd1_q, rd1_d;
    logic [CW-1:0] occ0_q, occ0_d, occ1_q, occ1_d;

    logic full0, full1;
    logic push0, push1, pop0, pop1;

    // Handshake decode
    assign full0      = (occ0_q == CW'(DEPTH));
    assign full1      = (occ1_q == CW'(DEPTH));
    // Full FIFO refuses even when it pops this cycle: no pass-through.
    assign in_ready   = ctrl ? ~full1 : ~full0;
    assign push0      = in_valid & in_ready & ~ctrl;
    assign push1      = in_valid & in_ready & ctrl;
    assign out0_valid = (occ0_q != '0);
    assign out1_valid = (occ1_q != '0);
    // outN_ready is ignored while the FIFO is empty.
    assign pop0       = out0_valid & out0_ready;
    assign pop1       = out1_valid & out1_ready;

    // Head words, forced to zero when empty so stale storage never shows.
    assign out0 = out0_valid ? mem0_q[rd0_q] : '0;
    assign out1 = out1_valid ? mem1_q[rd1_q] : '0;

    // Pointer and occupancy next state
    always_comb begin
        wr0_d  = wr0_q;
        rd0_d  = rd0_q;
        occ0_d = occ0_q;
        wr1_d  = wr1_q;
        rd1_d  = rd1_q;
        occ1_d = occ1_q;

        if (push0) wr0_d = wr0_q + AW'(1);
        if (pop0)  rd0_d = rd0_q + AW'(1);
        if (push1) wr1_d = wr1_q + AW'(1);
        if (pop1)  rd1_d = rd1_q + AW'(1);

        case ({push0, pop0})
            2'b10:   occ0_d = occ0_q + CW'(1);
            2'b01:   occ0_d = occ0_q - CW'(1);
            default: occ0_d = occ0_q;
        endcase

        case ({push1, pop1})
            2'b10:   occ1_d = occ1_q + CW'(1);
            2'b01:   occ1_d = occ1_q - CW'(1);
            default: occ1_d = occ1_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr0_q  <= '0;
            rd0_q  <= '0;
            occ0_q <= '0;
            wr1_q  <= '0;
            rd1_q  <= '0;
            occ1_q <= '0;
        end else begin
            wr0_q  <= wr0_d;
            rd0_q  <= rd0_d;
            occ0_q <= occ0_d;
            wr1_q  <= wr1_d;
            rd1_q  <= rd1_d;
            occ1_q <= occ1_d;
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wr0_q] <= in;
        if (push1) mem1_q[wr1_q] <= in;
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] dcnt0_q, dcnt1_q;

    // Delivered-word counters, wrap naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt0_q <= '0;
            dcnt1_q <= '0;
        end else begin
            if (pop0) dcnt0_q <= dcnt0_q + 16'd1;
            if (pop1) dcnt1_q <= dcnt1_q + 16'd1;
        end
    end

    assign cnt0 = dcnt0_q;
    assign cnt1 = dcnt1_q;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: vector table plus hand-written reset and
// counter sequences.
module tb_demux_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl;
    logic [31:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out0, out1;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
`ifdef DEMUX_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl       (ctrl),
        .in         (din),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
`ifdef DEMUX_CNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .out1_ready (out1_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ctrl;
        logic [31:0] din;
        logic        vld;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_o0;
        logic        e_v1;
        logic [31:0] e_o1;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic [31:0] d, input logic v,
                                input logic r0, input logic r1, input logic erdy,
                                input logic ev0, input logic [31:0] eo0,
                                input logic ev1, input logic [31:0] eo1);
        vec_t t;
        t.ctrl = c; t.din = d; t.vld = v; t.r0 = r0; t.r1 = r1;
        t.e_rdy = erdy; t.e_v0 = ev0; t.e_o0 = eo0; t.e_v1 = ev1; t.e_o1 = eo1;
        return t;
    endfunction

    // Called at a negedge: drive, check in_ready before the edge, check outputs after it.
    task automatic step(input vec_t v, input int idx);
        ctrl = v.ctrl; din = v.din; in_valid = v.vld;
        out0_ready = v.r0; out1_ready = v.r1;
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.e_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out0_valid", idx), 32'(out0_valid), 32'(v.e_v0));
        chk($sformatf("v%0d out0", idx), out0, v.e_o0);
        chk($sformatf("v%0d out1_valid", idx), 32'(out1_valid), 32'(v.e_v1));
        chk($sformatf("v%0d out1", idx), out1, v.e_o1);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " out0_valid"}, 32'(out0_valid), 32'd0);
        chk({tag, " out0"}, out0, 32'd0);
        chk({tag, " out1_valid"}, 32'(out1_valid), 32'd0);
        chk({tag, " out1"}, out1, 32'd0);
    endtask

`ifdef DEMUX_CNT_EN
    // Stream n words to one output with its consumer always ready.
    task automatic deliver(input logic c, input int n);
        in_valid = 1'b1; ctrl = c; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        // ctrl, din, vld, r0, r1 | in_ready, v0, out0, v1, out1
        vecs[0]  = mk(0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 32'hffff0000, 1, 1, 1, 1, 1, 32'hffff0000, 0, 32'h0);
        vecs[3]  = mk(1, 32'h0000ffff, 1, 1, 1, 1, 0, 32'h0,        1, 32'h0000ffff);
        vecs[4]  = mk(0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[5]  = mk(0, 32'h1,        1, 0, 1, 1, 1, 32'h1,        0, 32'h0);
        vecs[6]  = mk(0, 32'h2,        1, 0, 1, 1, 1, 32'h1,        0, 32'h0);
        vecs[7]  = mk(0, 32'h99,       1, 0, 1, 0, 1, 32'h1,        0, 32'h0);
        vecs[8]  = mk(1, 32'h3,        1, 0, 0, 1, 1, 32'h1,        1, 32'h3);
        vecs[9]  = mk(0, 32'h4,        1, 1, 0, 0, 1, 32'h2,        1, 32'h3);
        vecs[10] = mk(0, 32'h4,        1, 0, 0, 1, 1, 32'h2,        1, 32'h3);
        vecs[11] = mk(0, 32'h0,        0, 1, 0, 0, 1, 32'h4,        1, 32'h3);
        vecs[12] = mk(0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[13] = mk(0, 32'h5,        1, 1, 1, 1, 1, 32'h5,        0, 32'h0);
        vecs[14] = mk(0, 32'h6,        1, 1, 1, 1, 1, 32'h6,        0, 32'h0);
        vecs[15] = mk(1, 32'h7,        1, 1, 1, 1, 0, 32'h0,        1, 32'h7);
        vecs[16] = mk(0, 32'h0,        0, 1, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[17] = mk(0, 32'ha1,       1, 0, 0, 1, 1, 32'ha1,       0, 32'h0);
        vecs[18] = mk(0, 32'ha2,       1, 0, 0, 1, 1, 32'ha1,       0, 32'h0);
        vecs[19] = mk(1, 32'hb1,       1, 0, 0, 1, 1, 32'ha1,       1, 32'hb1);
        vecs[20] = mk(1, 32'hb2,       1, 0, 0, 1, 1, 32'ha1,       1, 32'hb1);

        rst_n = 1'b0; ctrl = 1'b0; din = '0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #20;
        rst_n = 1'b1;
        #1;
        check_idle("reset");
        chk("reset in_ready ctrl0", 32'(in_ready), 32'd1);
        ctrl = 1'b1;
        #1;
        chk("reset in_ready ctrl1", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < NV; i++) step(vecs[i], i);

        // Both FIFOs hold two words; reset asynchronously between edges.
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        out0_ready = 1'b1; out1_ready = 1'b1; ctrl = 1'b0;
        #1;
        chk("postreset in_ready ctrl0", 32'(in_ready), 32'd1);
        ctrl = 1'b1;
        #1;
        chk("postreset in_ready ctrl1", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("postreset idle%0d", i));
        end
        @(negedge clk);
        ctrl = 1'b0; din = 32'hc0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("postreset out0_valid", 32'(out0_valid), 32'd1);
        chk("postreset out0", out0, 32'hc0);
        chk("postreset out1_valid", 32'(out1_valid), 32'd0);
        @(posedge clk);
        #1;
        check_idle("postreset drained");
        @(negedge clk);

`ifdef DEMUX_CNT_EN
        rst_n = 1'b0;
        #1;
        chk("cnt0 reset", 32'(cnt0), 32'd0);
        chk("cnt1 reset", 32'(cnt1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        deliver(1'b0, 5);
        deliver(1'b1, 3);
        chk("cnt0 five", 32'(cnt0), 32'd5);
        chk("cnt1 three", 32'(cnt1), 32'd3);
        deliver(1'b0, 65530);
        chk("cnt0 max", 32'(cnt0), 32'hffff);
        deliver(1'b0, 1);
        chk("cnt0 wrap", 32'(cnt0), 32'h0);
        chk("cnt1 hold", 32'(cnt1), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
